// File: rtl/dac_serializer.sv
// dac_serializer
//   Buffers 16-bit sine samples from a DDS in a small FIFO and shifts each
//   one out MSB first as a 16-bit frame to a serial DAC.
//
//   Frame timing, with CLK_DIV clk cycles per sclk half-period:
//     - 16 bit periods of 2*CLK_DIV cycles each, with sync_n low.
//     - In each bit period sclk is high for the first half and low for the
//       second half. The DAC samples sdout on the falling edge of sclk.
//     - After the frame comes a 2*CLK_DIV cycle gap with sync_n high.
//     - Then one IDLE cycle, in which the next word is popped.
//
// Parameters
//   CLK_DIV     clk cycles per sclk half-period (1..255)
//   FIFO_DEPTH  sample buffer depth in words (power of two, 2..16)
//
// Ports
//   clk           single clock, all logic on its rising edge
//   reset         synchronous, active-high
//   sample        16-bit sample word, shifted out as raw two's-complement bits
//   sample_valid  one-cycle write strobe
//   sclk          serial clock, idles high
//   sync_n        frame select, active-low
//   sdout         serial data, MSB first
//   busy          high while the FIFO holds words or a frame/gap is running
//   overflow      sticky, set when a sample is dropped because the FIFO is full
//   fifo_count    number of buffered words, 0..FIFO_DEPTH
//
// Handshake: there is no back-pressure. A sample is taken whenever
// sample_valid is high and the FIFO has room. Room also exists when the FIFO
// is full but a word is popped in the same cycle. Otherwise the sample is
// dropped and overflow is set.
module dac_serializer #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample,
    input  logic        sample_valid,
    output logic        sclk,
    output logic        sync_n,
    output logic        sdout,
    output logic        busy,
    output logic        overflow,
    output logic [4:0]  fifo_count
);

    localparam int         AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] DEPTH    = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t        state;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [15:0]   shreg;
    logic [7:0]    div_cnt;
    logic          half;      // 0: first (sclk high) half, 1: second half
    logic [3:0]    bit_cnt;

    logic pop;
    logic full;
    logic wr;
    logic div_end;

    assign pop     = (state == IDLE) && (fifo_count != 5'd0);
    assign full    = (fifo_count == DEPTH);
    assign wr      = sample_valid && (!full || pop);
    assign div_end = (div_cnt == DIV_LAST);
    assign busy    = (fifo_count != 5'd0) || (state != IDLE);

    // Storage is not reset. Only the pointers and the count define its contents.
    always_ff @(posedge clk) begin
        if (!reset && wr) begin
            mem[wr_ptr] <= sample;
        end
    end

    // FIFO pointers, word count and the sticky overflow flag.
    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= 5'd0;
            overflow   <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr, pop})
                2'b10:   fifo_count <= fifo_count + 5'd1;
                2'b01:   fifo_count <= fifo_count - 5'd1;
                default: fifo_count <= fifo_count;
            endcase
            if (sample_valid && !wr) begin
                overflow <= 1'b1;
            end
        end
    end

    // Serializer FSM. All serial outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            sync_n  <= 1'b1;
            sclk    <= 1'b1;
            sdout   <= 1'b0;
            shreg   <= 16'd0;
            div_cnt <= 8'd0;
            half    <= 1'b0;
            bit_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg   <= mem[rd_ptr];
                        sdout   <= mem[rd_ptr][15];
                        sync_n  <= 1'b0;
                        sclk    <= 1'b1;
                        div_cnt <= 8'd0;
                        half    <= 1'b0;
                        bit_cnt <= 4'd0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!div_end) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= 8'd0;
                        if (!half) begin
                            half <= 1'b1;
                            sclk <= 1'b0;
                        end else begin
                            // End of a bit period: the next bit starts with sclk rising.
                            half <= 1'b0;
                            sclk <= 1'b1;
                            if (bit_cnt == 4'd15) begin
                                sync_n <= 1'b1;
                                sdout  <= 1'b0;
                                state  <= GAP;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                                shreg   <= shreg << 1;
                                sdout   <= shreg[14];
                            end
                        end
                    end
                end
                GAP: begin
                    // Two half-periods with sync_n high, then back to IDLE.
                    if (!div_end) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= 8'd0;
                        if (!half) begin
                            half <= 1'b1;
                        end else begin
                            half  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_serializer.sv
// Bench for dac_serializer (CLK_DIV=2, FIFO_DEPTH=4).
//
// The reference model holds a queue of buffered words, plus the start cycle
// and the word of the frame in flight. From those it computes the expected
// serial waveform by arithmetic on the offset into the frame.
//
// A compare process checks every output on every negedge.
// A monitor decodes the DAC view: bits are taken on sclk falls while sync_n
// is low, and the length of each sync_n run is measured.
// Literal checks then pin the decoded words and run lengths.
module tb_dac_serializer;
    localparam int D     = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sample = 16'd0;
    logic        sample_valid = 1'b0;
    logic        sclk, sync_n, sdout, busy, overflow;
    logic [4:0]  fifo_count;

    int tests = 0;
    int fails = 0;

    dac_serializer #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .sample(sample), .sample_valid(sample_valid),
        .sclk(sclk), .sync_n(sync_n), .sdout(sdout), .busy(busy),
        .overflow(overflow), .fifo_count(fifo_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] exp_q[$];
    int          cyc = 0;
    bit          m_active = 0;
    int          m_p = 0;
    logic [15:0] m_word = 16'd0;
    bit          m_ovf = 0;

    function automatic bit model_idle();
        return !m_active || (cyc > m_p + 34 * D);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_active = 0;
            m_ovf    = 0;
        end else begin
            if (model_idle() && exp_q.size() > 0) begin
                m_word   = exp_q.pop_front();
                m_p      = cyc;
                m_active = 1;
            end
            if (sample_valid) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(sample);
                else m_ovf = 1;
            end
        end
        cyc++;
    end

    // ---------------- compare process ----------------
    bit check_en = 0;

    always @(negedge clk) begin
        if (check_en) begin
            int  k;
            bit  e_sync, e_sclk, e_sd, e_busy;
            k      = cyc - m_p - 1;
            e_sync = 1; e_sclk = 1; e_sd = 0;
            if (m_active && k < 32 * D) begin
                e_sync = 0;
                e_sclk = ((k % (2 * D)) < D);
                e_sd   = m_word[15 - k / (2 * D)];
            end
            e_busy = (exp_q.size() != 0) || (m_active && k < 34 * D);
            check("sync_n", 32'(sync_n), 32'(e_sync));
            check("sclk", 32'(sclk), 32'(e_sclk));
            check("sdout", 32'(sdout), 32'(e_sd));
            check("busy", 32'(busy), 32'(e_busy));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
        end
    end

    // ---------------- DAC-side monitor ----------------
    logic [15:0] rx_q[$];
    logic [15:0] rx_sh = 16'd0;
    int          rx_bits = 0;
    int          low_run = 0, high_run = 0, last_low = 0, last_high = 0;
    logic        p_sclk = 1'b1, p_sync = 1'b1;

    always @(negedge clk) begin
        if (reset) begin
            rx_bits  = 0;
            low_run  = 0;
            high_run = 0;
        end else begin
            if (sync_n === 1'b0) begin
                if (p_sync === 1'b1) begin
                    last_high = high_run;
                    rx_bits   = 0;
                    low_run   = 0;
                end
                low_run++;
                if (p_sclk === 1'b1 && sclk === 1'b0) begin
                    rx_sh = {rx_sh[14:0], sdout};
                    rx_bits++;
                end
            end else begin
                if (p_sync === 1'b0) begin
                    last_low = low_run;
                    if (rx_bits == 16) rx_q.push_back(rx_sh);
                    high_run = 0;
                end
                high_run++;
            end
        end
        p_sclk = sclk;
        p_sync = sync_n;
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b1;
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic strobe(input logic [15:0] w);
        sample = w;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] sent[6];
    int          n0;
    bit          hit;

    initial begin
        @(negedge clk);
        do_reset();
        check_en = 1;

        // Reset state.
        check("rst_fifo_count", 32'(fifo_count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sync_n", 32'(sync_n), 1);
        check("rst_overflow", 32'(overflow), 0);

        // Single word into an idle block.
        n0 = rx_q.size();
        strobe(16'hA5C3);
        check("lat_n1_sync", 32'(sync_n), 1);
        @(negedge clk);
        check("lat_n2_sync", 32'(sync_n), 0);
        repeat (80) @(negedge clk);
        check("single_words", 32'(rx_q.size() - n0), 1);
        if (rx_q.size() > n0) check("single_data", 32'(rx_q[n0]), 32'hA5C3);
        check("single_low_run", 32'(last_low), 64);
        check("single_busy_end", 32'(busy), 0);

        // Six strobes in consecutive cycles.
        n0 = rx_q.size();
        for (int i = 0; i < 6; i++) begin
            sent[i] = 16'($urandom);
            sample = sent[i];
            sample_valid = 1'b1;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        check("six_fifo_count", 32'(fifo_count), 4);
        check("six_overflow", 32'(overflow), 1);
        repeat (5 * (34 * D + 1) + 10) @(negedge clk);
        check("six_words", 32'(rx_q.size() - n0), 5);
        for (int i = 0; i < 5; i++)
            if (rx_q.size() > n0 + i) check("six_data", 32'(rx_q[n0 + i]), 32'(sent[i]));

        // FIFO full and a pop in the same cycle as a write.
        do_reset();
        for (int i = 0; i < 5; i++) strobe(16'($urandom));
        hit = 0;
        for (int t = 0; t < 200 && !hit; t++) begin
            if (model_idle() && exp_q.size() == DEPTH) begin
                hit = 1;
                strobe(16'h1234);
            end else begin
                @(negedge clk);
            end
        end
        check("full_pop_reached", 32'(hit), 1);
        check("full_pop_count", 32'(fifo_count), 4);
        check("full_pop_ovf", 32'(overflow), 0);
        repeat (5 * (34 * D + 1) + 10) @(negedge clk);

        // Reset in bit 7 of a frame with 2 words buffered.
        do_reset();
        for (int i = 0; i < 3; i++) strobe(16'($urandom));
        hit = 0;
        for (int t = 0; t < 200 && !hit; t++) begin
            if (m_active && (cyc - m_p - 1) == 7 * 2 * D) hit = 1;
            else @(negedge clk);
        end
        check("bit7_reached", 32'(hit), 1);
        check("bit7_count", 32'(fifo_count), 2);
        n0 = rx_q.size();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_sync_n", 32'(sync_n), 1);
        check("abort_sclk", 32'(sclk), 1);
        check("abort_count", 32'(fifo_count), 0);
        check("abort_ovf", 32'(overflow), 0);
        repeat (150) @(negedge clk);
        check("abort_no_frames", 32'(rx_q.size() - n0), 0);

        // 0x8000 then 0x7FFF back-to-back.
        n0 = rx_q.size();
        strobe(16'h8000);
        strobe(16'h7FFF);
        repeat (2 * (34 * D + 1) + 10) @(negedge clk);
        check("b2b_words", 32'(rx_q.size() - n0), 2);
        if (rx_q.size() > n0 + 1) begin
            check("b2b_first", 32'(rx_q[n0]), 32'h8000);
            check("b2b_second", 32'(rx_q[n0 + 1]), 32'h7FFF);
        end
        check("b2b_gap", 32'(last_high), 5);

        // Randomized traffic with varying density and occasional reset.
        for (int blk = 0; blk < 8; blk++) begin
            int dens;
            dens = $urandom_range(1, 60);
            for (int t = 0; t < 400; t++) begin
                reset        = ($urandom_range(0, 599) == 0);
                sample       = 16'($urandom);
                sample_valid = ($urandom_range(0, 99) < dens);
                @(negedge clk);
            end
        end
        reset = 1'b0;
        sample_valid = 1'b0;
        repeat (400) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dac_serializer.md
DAC_SERIALIZER -- requirements
Module: dac_serializer

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per sclk half-period; legal range 1..255.
REQ-002 Parameter FIFO_DEPTH, default 4: sample buffer depth in words; power of two, 2..16.
REQ-003 Port clk  input  1  the single clock; all logic on posedge clk.
REQ-004 Port reset  input  1  reset, synchronous and active-high.
REQ-005 Port sample  input  16  sine sample word from the DDS output q.
REQ-006 Port sample_valid  input  1  one-cycle strobe; connects to the DDS ready output.
REQ-007 Port sclk  output  1  serial DAC clock; idles high.
REQ-008 Port sync_n  output  1  DAC frame select, active-low.
REQ-009 Port sdout  output  1  serial data, MSB first.
REQ-010 Port busy  output  1  high while the FIFO is non-empty or a frame is in progress.
REQ-011 Port overflow  output  1  sticky flag; set when a sample is dropped.
REQ-012 Port fifo_count  output  5  number of words currently buffered, 0..FIFO_DEPTH.

Function
REQ-013 A sample is written into the FIFO at the posedge where sample_valid=1 and the FIFO is not full, or where the FIFO is full and a pop occurs in the same cycle.
REQ-014 sample_valid=1 while the FIFO is full with no same-cycle pop drops the word, leaves the FIFO unchanged, and sets overflow=1 until reset.
REQ-015 Serializer FSM states: IDLE, SHIFT, GAP; all outputs are registered.
REQ-016 IDLE with fifo_count>0: pop the head word into a 16-bit shift register and enter SHIFT; in the next cycle sync_n=0, sclk=1, sdout=bit 15.
REQ-017 SHIFT: 16 bit periods of 2*CLK_DIV cycles each; sclk=1 for the first CLK_DIV cycles and sclk=0 for the last CLK_DIV cycles of each period.
REQ-018 The DAC samples on the sclk falling edge; sdout changes only at bit-period start, i.e. together with an sclk rising edge or the sync_n falling edge.
REQ-019 After the 16th bit period: sync_n=1, sclk=1, sdout=0; enter GAP for 2*CLK_DIV cycles, then return to IDLE.
REQ-020 From IDLE the next pop occurs in the first IDLE cycle; back-to-back frames therefore repeat every 34*CLK_DIV+1 cycles.
REQ-021 Latency: with the FIFO empty and in IDLE, a sample_valid in cycle N produces sync_n=0 in cycle N+2.
REQ-022 fifo_count increments on a write, decrements on a pop, and is unchanged on a simultaneous write and pop; read and write pointers wrap modulo FIFO_DEPTH.
REQ-023 busy=1 when fifo_count!=0 or state!=IDLE, evaluated on the registered state.
REQ-024 The sample word is shifted as raw two's-complement bits with no offset conversion.

Reset
REQ-025 reset=1 at a posedge forces IDLE, empty FIFO (pointers and fifo_count 0), overflow=0, sync_n=1, sclk=1, sdout=0, busy=0.
REQ-026 reset asserted mid-frame aborts the frame immediately; the partial word is discarded; sync_n=1 in the cycle after the reset edge.
REQ-027 sample_valid is ignored in any cycle with reset=1.

Verification (CLK_DIV=2, FIFO_DEPTH=4)
REQ-028 Single sample 0xA5C3 into idle block -> sync_n low for exactly 64 cycles starting at N+2; bits captured on sclk falls = 1010010111000011; then sync_n high for 4 cycles; busy falls afterward.
REQ-029 Six sample_valid strobes in consecutive cycles -> first word popped immediately, next four buffered (fifo_count=4), sixth dropped; overflow=1; five frames emitted in order.
REQ-030 FIFO full and a pop in the same cycle as sample_valid -> word accepted, fifo_count stays 4, overflow stays 0.
REQ-031 Reset asserted at bit 7 of a frame with 2 words buffered -> next cycle sync_n=1, sclk=1, fifo_count=0, overflow=0; no further frames are emitted.
REQ-032 Samples 0x8000 then 0x7FFF back-to-back -> two frames separated by exactly 5 sync_n-high cycles (GAP plus the IDLE pop cycle); data bits match exactly.
